alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked execute unit for the RISC-V core. It performs the RV32I integer operations with registered results and flags, and adds the M-extension (multiply, divide, remainder) as iterative multi-cycle operations. It sits between the decode/operand-read stage and writeback, and uses valid/ready handshakes on both the input and output sides so that the pipeline stalls on long operations.

## Interface
- `WIDTH`, 32: operand and result width; must be at least 8 and a power of two.
- `CTRL_W`, 5: width of the opcode field.
- `SHAMT_W`, $clog2(WIDTH): shift-amount bits taken from `srcB`; derived, do not override.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `kill`  in  1  abort the operation in flight (pipeline flush).
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  the unit can accept an operation.
- `ALUcontrol`  in  CTRL_W  opcode (encoding under Operation).
- `srcA`, `srcB`  in  WIDTH each  operands.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `ALUresult`  out  WIDTH  registered result.
- `zero`, `negative`, `overflow`, `carry`  out  1 each  registered flags.

## Operation
- Opcodes 0–9: add, sub, and, or, xor, sll, srl, sltu, sra, slt.
- Opcodes 10–17: mul, mulh, mulhsu, mulhu, div, divu, rem, remu. All other codes produce a result of 0 with all flags 0.
- Add and sub:
  - Use `sum = srcA + (op[0] ? ~srcB : srcB) + op[0]`, computed WIDTH+1 bits wide.
  - `carry` = sum[WIDTH]; `overflow` = (srcA[msb] ^ sum[msb]) & ~(srcA[msb] ^ srcB[msb] ^ op[0]).
- Compares:
  - sltu returns ~carry of the subtraction.
  - slt returns sum[msb] ^ overflow.
  - Both compute the subtraction internally regardless of op[0].
- `zero` = ~|result and `negative` = result[msb] for every opcode.
- `overflow` and `carry` are meaningful for opcodes 0, 1, 7 and 9 only; they are 0 for all others.
- Shifts use srcB[SHAMT_W-1:0]; sra is arithmetic.
- Multiply:
  - Radix-2 shift-add over the full 2·WIDTH-bit product, one bit per cycle, WIDTH iterations.
  - Signed operands are converted to magnitude first; the product sign is corrected at the end.
  - mul returns the low half; mulh, mulhsu and mulhu return the high half.
- Divide: restoring algorithm, one quotient bit per cycle, WIDTH iterations. The remainder takes the dividend's sign.
- Divide special cases complete in the fast path:
  - Divide by zero: quotient = all ones; remainder = srcA.
  - Signed overflow (srcA = most-negative value, srcB = −1): quotient = srcA; remainder = 0.
- State machine:
  - IDLE → FAST on accept of a single-cycle op or a divide special case.
  - IDLE → ITER on accept of any other mul/div op.
  - ITER → DONE when the iteration counter reaches WIDTH−1.
  - FAST → DONE on the next edge.
  - DONE → IDLE when `out_ready` is high.
- `in_ready` = (state == IDLE). There is no back-to-back overlap: the next accept is possible the cycle after the DONE handshake.
- `kill` returns the FSM to IDLE from any state on the next edge and drops `out_valid`. Input accepted in the same cycle as `kill` is discarded.

## Timing
- Reset:
  - state = IDLE; `in_ready` = 1; `out_valid` = 0; `ALUresult` = 0.
  - `zero` = 1, `negative` = 0, `overflow` = 0, `carry` = 0.
  - The iteration counter resets to 0.
  - A reset mid-operation loses the operation with no output.
- Single-cycle ops and divide special cases: accepted at edge N; `out_valid` is high from edge N+2.
- Iterative ops: `out_valid` is high from edge N+WIDTH+2.
- While `out_valid` is high and `out_ready` is low:
  - `ALUresult` and all flags hold stable.
  - `in_ready` stays low.
- `kill` and `reset` take priority over the `out_ready` handshake. `reset` takes priority over `kill`.
- Operands and opcode are captured at accept; input changes during ITER have no effect.

## Structure
- Package `alu_pkg` holds:
  - the `alu_op_e` opcode enum, CTRL_W bits wide, values 0–17;
  - the state enum `alu_state_e` (IDLE, FAST, ITER, DONE);
  - helper functions `is_muldiv(op)` and `is_signed_div(op)`.
- Sub-module `muldiv_iter` holds the shared shift/accumulate datapath and iteration counter. Its interface is start, op, srcA, srcB, done and a 2·WIDTH-bit result. The top level keeps the handshake FSM, the fast path and the flag registers.

## Test plan
- add 0x7FFFFFFF + 1 → result 0x80000000, overflow = 1, negative = 1, carry = 0; `out_valid` at accept+2.
- sub 5 − 5 → 0, zero = 1, carry = 1; sltu 1 vs 2 → 1; slt −1 vs 1 → 1; sra 0x80000000 by 4 → 0xF8000000.
- mulh −2 × 3 → 0xFFFFFFFF; mul gives 0xFFFFFFFA; `out_valid` at accept+34 (WIDTH = 32).
- div 7 / 0 → 0xFFFFFFFF and rem 7 / 0 → 7, both at accept+2. div 0x80000000 / −1 → 0x80000000; rem → 0.
- Hold `out_ready` = 0 for 5 cycles after divu 100/7 → result 14 stable throughout, `in_ready` low. Releasing `out_ready` returns the unit to IDLE with `in_ready` high the next cycle.
- Assert `kill` at iteration 10 of a div, and separately `reset` mid-mul → IDLE next edge, `out_valid` never high, reset values on all outputs. A following add 2 + 3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: opcode/state enums and decode helpers for the alu_seq unit   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

   localparam int ALU_CTRL_W = 5;

   typedef enum logic [ALU_CTRL_W-1:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SLTU   = 5'd7,
      OP_SRA    = 5'd8,
      OP_SLT    = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FAST = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } alu_state_e;

   function automatic logic is_muldiv(input alu_op_e op);
      return (op >= OP_MUL);
   endfunction

   function automatic logic is_div(input alu_op_e op);
      return (op >= OP_DIV);
   endfunction

   function automatic logic is_signed_div(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_iter: radix-2 shift-add multiplier / restoring divider         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  alu_op_e            op,
   input  logic [WIDTH-1:0]   srcA,
   input  logic [WIDTH-1:0]   srcB,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   logic               r_busy;
   logic               r_div;
   logic               r_neg;
   logic               r_rneg;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_opd;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic [2*WIDTH-1:0] w_prod;

   always_comb begin
      w_a_neg     = srcA[WIDTH-1] &
                    (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      w_b_neg     = srcB[WIDTH-1] & (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
      w_mag_a     = w_a_neg ? -srcA : srcA;
      w_mag_b     = w_b_neg ? -srcB : srcB;
      w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
      w_div_shift = {r_hi, r_lo[WIDTH-1]};
      w_div_diff  = w_div_shift - {1'b0, r_opd};
      w_prod      = {r_hi, r_lo};
   end

   // Multiply: r_hi accumulates, {r_hi,r_lo} shifts right; divide: r_hi is the
   // partial remainder and r_lo shifts the dividend out / quotient in.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_div  <= 1'b0;
         r_neg  <= 1'b0;
         r_rneg <= 1'b0;
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_opd  <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_div  <= is_div(op);
         r_neg  <= w_a_neg ^ w_b_neg;
         r_rneg <= w_a_neg;
         r_cnt  <= '0;
         r_hi   <= '0;
         r_lo   <= is_div(op) ? w_mag_a : w_mag_b;
         r_opd  <= is_div(op) ? w_mag_b : w_mag_a;
      end else if (r_busy) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == c_last) r_busy <= 1'b0;
         if (!r_div) begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
         end else if (!w_div_diff[WIDTH]) begin
            r_hi <= w_div_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
         end else begin
            r_hi <= w_div_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      done = r_busy && (r_cnt == c_last);
      if (r_div)
         result = {(r_rneg ? -r_hi : r_hi), (r_neg ? -r_lo : r_lo)};
      else
         result = r_neg ? -w_prod : w_prod;
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq: handshaked RV32IM execute unit with registered result/flags  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CTRL_W  = 5,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              kill,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ALUcontrol,
   input  logic [WIDTH-1:0]  srcA,
   input  logic [WIDTH-1:0]  srcB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  ALUresult,
   output logic              zero,
   output logic              negative,
   output logic              overflow,
   output logic              carry
);

   localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

   alu_state_e         r_state;
   alu_state_e         w_next;
   alu_op_e            r_op;
   logic               r_op_ok;
   logic               r_use_md;
   logic               r_start;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_neg;
   logic               r_ovf;
   logic               r_carry;

   alu_op_e            w_in_op;
   logic               w_in_ok;
   logic               w_in_iter;
   logic               w_accept;
   logic               w_md_rst;
   logic               w_md_done;
   logic [2*WIDTH-1:0] w_md_res;
   logic               w_dosub;
   logic [WIDTH:0]     w_sum;
   logic               w_ovf;
   logic               w_arith;
   logic [WIDTH-1:0]   w_fast;
   logic [WIDTH-1:0]   w_res;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign ALUresult = r_result;
   assign zero      = r_zero;
   assign negative  = r_neg;
   assign overflow  = r_ovf;
   assign carry     = r_carry;

   // Divide-by-zero and signed overflow bypass the iterator entirely.
   always_comb begin
      w_in_ok   = (ALUcontrol <= CTRL_W'(17));
      w_in_op   = alu_op_e'(ALUcontrol[ALU_CTRL_W-1:0]);
      w_in_iter = w_in_ok && is_muldiv(w_in_op) &&
                  !(is_div(w_in_op) && ((srcB == '0) ||
                    (is_signed_div(w_in_op) && srcA == c_min_neg && srcB == '1)));
      w_accept  = in_valid && in_ready && !kill;
      w_md_rst  = reset || kill;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = w_in_iter ? S_ITER : S_FAST;
         S_FAST:  w_next = S_DONE;
         S_ITER:  if (w_md_done) w_next = S_DONE;
         S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (kill) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= OP_ADD;
         r_op_ok  <= 1'b0;
         r_use_md <= 1'b0;
         r_start  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
      end else begin
         r_start <= w_accept && w_in_iter;
         if (w_accept) begin
            r_op     <= w_in_op;
            r_op_ok  <= w_in_ok;
            r_use_md <= w_in_iter;
            r_a      <= srcA;
            r_b      <= srcB;
         end
      end
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (w_md_rst),
      .start  (r_start),
      .op     (r_op),
      .srcA   (r_a),
      .srcB   (r_b),
      .done   (w_md_done),
      .result (w_md_res)
   );

   // Compares always subtract so carry/overflow describe srcA - srcB.
   always_comb begin
      w_dosub = (r_op != OP_ADD);
      w_sum   = {1'b0, r_a} + {1'b0, (w_dosub ? ~r_b : r_b)} + {{WIDTH{1'b0}}, w_dosub};
      w_ovf   = (r_a[WIDTH-1] ^ w_sum[WIDTH-1]) & ~(r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_dosub);
      w_arith = r_op_ok && (r_op inside {OP_ADD, OP_SUB, OP_SLTU, OP_SLT});
      w_fast  = '0;
      case (r_op)
         OP_ADD, OP_SUB: w_fast = w_sum[WIDTH-1:0];
         OP_AND:  w_fast = r_a & r_b;
         OP_OR:   w_fast = r_a | r_b;
         OP_XOR:  w_fast = r_a ^ r_b;
         OP_SLL:  w_fast = r_a << r_b[SHAMT_W-1:0];
         OP_SRL:  w_fast = r_a >> r_b[SHAMT_W-1:0];
         OP_SRA:  w_fast = $signed(r_a) >>> r_b[SHAMT_W-1:0];
         OP_SLTU: w_fast = {{(WIDTH-1){1'b0}}, ~w_sum[WIDTH]};
         OP_SLT:  w_fast = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
         OP_DIV:  w_fast = (r_b == '0) ? '1 : r_a;
         OP_DIVU: w_fast = '1;
         OP_REM:  w_fast = (r_b == '0) ? r_a : '0;
         OP_REMU: w_fast = r_a;
         default: w_fast = '0;
      endcase
      if (!r_op_ok)
         w_res = '0;
      else if (r_use_md)
         w_res = (r_op inside {OP_MUL, OP_DIV, OP_DIVU}) ? w_md_res[WIDTH-1:0]
                                                         : w_md_res[2*WIDTH-1:WIDTH];
      else
         w_res = w_fast;
   end

   // DONE spends its first cycle loading the result, then waits for out_ready.
   always_ff @(posedge clk) begin
      if (reset || kill) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_neg       <= 1'b0;
         r_ovf       <= 1'b0;
         r_carry     <= 1'b0;
      end else if (r_state == S_DONE) begin
         if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= r_op_ok && (w_res == '0);
            r_neg       <= w_res[WIDTH-1];
            r_ovf       <= w_arith && w_ovf;
            r_carry     <= w_arith && w_sum[WIDTH];
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_seq: directed + random bench for alu_seq against a 64-bit model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset, kill, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]  ALUcontrol;
   logic [31:0] srcA, srcB, ALUresult;
   logic        zero, negative, overflow, carry;

   int n_asrt = 0;
   int n_fail = 0;

   localparam logic [31:0] MINV = 32'h8000_0000;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   alu_seq #(.WIDTH(32), .CTRL_W(5)) dut (
      .clk(clk), .reset(reset), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
      .ALUcontrol(ALUcontrol), .srcA(srcA), .srcB(srcB), .out_valid(out_valid),
      .out_ready(out_ready), .ALUresult(ALUresult), .zero(zero), .negative(negative),
      .overflow(overflow), .carry(carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_asrt++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic in_range(input longint t);
      longint hi, lo;
      hi = 64'sd2147483647;
      lo = -64'sd2147483648;
      return (t <= hi) && (t >= lo);
   endfunction

   // Returns {result, zero, negative, overflow, carry}.
   function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub, t;
      logic [63:0] p;
      logic [31:0] r;
      logic v, c;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
      r = '0; v = 1'b0; c = 1'b0; t = 0; p = '0;
      case (op)
         5'd0: begin t = sa + sb; r = a + b; p = ua + ub; c = p[32]; v = !in_range(t); end
         5'd1, 5'd7, 5'd9: begin
            t = sa - sb; c = (a >= b); v = !in_range(t);
            r = (op == 5'd1) ? a - b : (op == 5'd7) ? {31'd0, a < b} : {31'd0, sa < sb};
         end
         5'd2: r = a & b;
         5'd3: r = a | b;
         5'd4: r = a ^ b;
         5'd5: r = a << b[4:0];
         5'd6: r = a >> b[4:0];
         5'd8: begin t = sa >>> b[4:0]; r = t[31:0]; end
         5'd10: begin p = sa * sb; r = p[31:0]; end
         5'd11: begin p = sa * sb; r = p[63:32]; end
         5'd12: begin p = sa * ub; r = p[63:32]; end
         5'd13: begin p = ua * ub; r = p[63:32]; end
         5'd14: if (b == 0) r = ONES; else if (a == MINV && b == ONES) r = a;
                else begin t = sa / sb; r = t[31:0]; end
         5'd15: if (b == 0) r = ONES; else begin t = ua / ub; r = t[31:0]; end
         5'd16: if (b == 0) r = a; else if (a == MINV && b == ONES) r = '0;
                else begin t = sa % sb; r = t[31:0]; end
         5'd17: if (b == 0) r = a; else begin t = ua % ub; r = t[31:0]; end
         default: return 36'd0;
      endcase
      return {r, (r == 32'd0), r[31], v, c};
   endfunction

   function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op < 5'd10 || op > 5'd17) return 2;
      if (op >= 5'd14 && b == 0) return 2;
      if ((op == 5'd14 || op == 5'd16) && a == MINV && b == ONES) return 2;
      return 34;
   endfunction

   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
      logic [35:0] e;
      int lat;
      e = model(op, a, b);
      @(negedge clk);
      chk("in_ready_before", in_ready, 1);
      ALUcontrol = op; srcA = a; srcB = b; in_valid = 1'b1; out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0; srcA = $urandom; srcB = $urandom; ALUcontrol = 5'($urandom_range(0, 31));
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      chk($sformatf("latency op%0d", op), 64'(lat), 64'(exp_latency(op, a, b)));
      chk($sformatf("result op%0d a=%h b=%h", op, a, b), ALUresult, e[35:4]);
      chk($sformatf("flags op%0d a=%h b=%h", op, a, b), {zero, negative, overflow, carry}, e[3:0]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_result", ALUresult, e[35:4]);
         chk("hold_valid_ready", {out_valid, in_ready}, 2'b10);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("after_handshake", {out_valid, in_ready}, 2'b01);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_hs"}, {in_ready, out_valid}, 2'b10);
      chk({tag, "_result"}, ALUresult, 0);
      chk({tag, "_flags"}, {zero, negative, overflow, carry}, 4'b1000);
   endtask

   task automatic no_valid_for(input string tag, input int n);
      logic saw;
      saw = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk(tag, saw, 0);
   endtask

   task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ALUcontrol = op; srcA = a; srcB = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return ONES;
         2: return MINV;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [4:0] op;
      reset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ALUcontrol = '0; srcA = '0; srcB = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_reset_state("reset");

      do_op(5'd0, 32'h7FFF_FFFF, 32'd1, 0);
      do_op(5'd1, 32'd5, 32'd5, 0);
      do_op(5'd7, 32'd1, 32'd2, 0);
      do_op(5'd9, ONES, 32'd1, 0);
      do_op(5'd8, MINV, 32'd4, 0);
      do_op(5'd11, 32'hFFFF_FFFE, 32'd3, 0);
      do_op(5'd10, 32'hFFFF_FFFE, 32'd3, 0);
      do_op(5'd14, 32'd7, 32'd0, 0);
      do_op(5'd16, 32'd7, 32'd0, 0);
      do_op(5'd14, MINV, ONES, 0);
      do_op(5'd16, MINV, ONES, 0);
      do_op(5'd15, 32'd100, 32'd7, 5);

      // Kill part-way through a divide.
      launch(5'd14, 32'd1000, 32'd7);
      repeat (11) @(posedge clk);
      @(negedge clk); kill = 1'b1;
      @(posedge clk); #1; kill = 1'b0;
      chk_reset_state("kill");
      no_valid_for("kill_no_valid", 40);

      // An op offered together with kill must be dropped.
      @(negedge clk);
      ALUcontrol = 5'd0; srcA = 32'd9; srcB = 32'd9; in_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; kill = 1'b0;
      chk("kill_accept_ready", in_ready, 1);
      no_valid_for("kill_accept_no_valid", 5);

      // Reset part-way through a multiply.
      launch(5'd10, 32'd12345, 32'd678);
      repeat (15) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      chk_reset_state("midreset");
      no_valid_for("reset_no_valid", 40);
      do_op(5'd0, 32'd2, 32'd3, 0);

      for (int i = 0; i < 60; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 19));
         do_op(op, pick(), pick(), ($urandom_range(0, 5) == 0) ? 2 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
